wavelet_decimator: RTL and testbench

//   Dyadic (by-2) downsampler that sits directly downstream of the wavelet FIR filter stage.

---
 rtl/wavelet_decimator.sv | 200 ++++++++++++++++++++
 tb/tb_wavelet_decimator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wavelet_decimator.sv
// Dyadic downsampler: drops the filter warm-up transient, keeps one sample in two and buffers
// kept samples in a small FIFO with a valid/ready output. Optional DECIM_OVF_EN adds ovf/drop_cnt.
module wavelet_decimator #(
    parameter int DATA_WIDTH = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int WARMUP     = 9,
    parameter int PHASE      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          x_valid,
    input  logic [DATA_WIDTH-1:0]         x,
    output logic [DATA_WIDTH-1:0]         y,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef DECIM_OVF_EN
    ,
    output logic                          ovf,
    output logic [7:0]                    drop_cnt
`endif
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic PHASE_BIT = (PHASE != 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [WCW-1:0]         warm_cnt_r;
    logic [WCW-1:0]         warm_cnt_next_s;
    logic                   phase_r;
    logic                   phase_next_s;
    logic                   kept_s;

    logic [DATA_WIDTH-1:0]  mem_r [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr_r;
    logic [AW-1:0]          wr_ptr_r;
    logic [LW-1:0]          level_r;
    logic                   y_valid_r;
    logic [DATA_WIDTH-1:0]  y_r;

    logic                   full_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   drop_s;
    logic [AW-1:0]          rd_ptr_next_s;
    logic [AW-1:0]          wr_ptr_next_s;
    logic [LW-1:0]          level_next_s;
    logic [DATA_WIDTH-1:0]  y_next_s;

    // State, warm-up counter and phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RESET_STATE;
            warm_cnt_r <= {WCW{1'b0}};
            phase_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            warm_cnt_r <= warm_cnt_next_s;
            phase_r    <= phase_next_s;
        end
    end

    // Next-state logic and keep decision; phase advances on every accepted RUN sample.
    always_comb begin
        state_next_s    = state_r;
        warm_cnt_next_s = warm_cnt_r;
        phase_next_s    = phase_r;
        kept_s          = 1'b0;
        case (state_r)
            ST_WARMUP: begin
                phase_next_s = 1'b0;
                if (x_valid) begin
                    warm_cnt_next_s = warm_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
                    if (warm_cnt_r == WCW'(WARMUP - 1)) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_WARMUP;
                    end
                end else begin
                    warm_cnt_next_s = warm_cnt_r;
                end
            end
            ST_RUN: begin
                if (x_valid) begin
                    kept_s       = (phase_r == PHASE_BIT);
                    phase_next_s = ~phase_r;
                end else begin
                    kept_s       = 1'b0;
                end
            end
            default: begin
                state_next_s    = RESET_STATE;
                warm_cnt_next_s = {WCW{1'b0}};
                phase_next_s    = 1'b0;
            end
        endcase
    end

    assign full_s = (level_r == LW'(FIFO_DEPTH));
    assign pop_s  = y_valid_r & y_ready;
    assign push_s = kept_s & (~full_s | pop_s);
    assign drop_s = kept_s & full_s & ~pop_s;

    // FIFO pointer/occupancy update and look-ahead of the next head so y is registered.
    always_comb begin
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        level_next_s  = level_r;
        y_next_s      = {DATA_WIDTH{1'b0}};
        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (push_s && !pop_s) begin
            level_next_s = level_r + {{(LW-1){1'b0}}, 1'b1};
        end else if (pop_s && !push_s) begin
            level_next_s = level_r - {{(LW-1){1'b0}}, 1'b1};
        end else begin
            level_next_s = level_r;
        end
        // The new head may be the slot being written this very cycle.
        if (level_next_s == {LW{1'b0}}) begin
            y_next_s = {DATA_WIDTH{1'b0}};
        end else if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
            y_next_s = x;
        end else begin
            y_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage, pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            rd_ptr_r  <= {AW{1'b0}};
            wr_ptr_r  <= {AW{1'b0}};
            level_r   <= {LW{1'b0}};
            y_valid_r <= 1'b0;
            y_r       <= {DATA_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= x;
            end
            rd_ptr_r  <= rd_ptr_next_s;
            wr_ptr_r  <= wr_ptr_next_s;
            level_r   <= level_next_s;
            y_valid_r <= (level_next_s != {LW{1'b0}});
            y_r       <= y_next_s;
        end
    end

    assign y       = y_r;
    assign y_valid = y_valid_r;
    assign level   = level_r;

`ifdef DECIM_OVF_EN
    logic       ovf_r;
    logic [7:0] drop_cnt_r;

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r      <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else begin
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
            if (drop_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    assign ovf      = ovf_r;
    assign drop_cnt = drop_cnt_r;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_s;
`endif

endmodule

// File: tb/tb_wavelet_decimator.sv
// Self-checking bench for wavelet_decimator: table vectors, hand sequences and random stimulus
// against a queue-based reference model. Two instances: PHASE=0 (modelled) and PHASE=1.
module tb_wavelet_decimator;

    localparam int DW = 11;
    localparam int D  = 4;
    localparam int WU = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          x_valid;
    logic [DW-1:0] x;
    logic          y_ready;
    logic [DW-1:0] y0, y1;
    logic          yv0, yv1;
    logic [2:0]    lvl0, lvl1;
`ifdef DECIM_OVF_EN
    logic          ovf0, ovf1;
    logic [7:0]    dc0, dc1;
`endif

    wavelet_decimator #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .WARMUP(WU), .PHASE(0)) u_dut0 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .y(y0), .y_valid(yv0),
        .y_ready(y_ready), .level(lvl0)
`ifdef DECIM_OVF_EN
        , .ovf(ovf0), .drop_cnt(dc0)
`endif
    );

    wavelet_decimator #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .WARMUP(WU), .PHASE(1)) u_dut1 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .y(y1), .y_valid(yv1),
        .y_ready(y_ready), .level(lvl1)
`ifdef DECIM_OVF_EN
        , .ovf(ovf1), .drop_cnt(dc1)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state (PHASE=0 instance)
    int q[$];
    int acc;
    int drops;
    bit ovf_m;
    int seq0[$];
    int seq1[$];

    typedef struct {
        bit v;
        int xv;
        bit rdy;
        int ey;
        bit ev;
        int el;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        acc   = 0;
        drops = 0;
        ovf_m = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model, then compare just after the edge.
    task automatic step(input bit v, input int xv, input bit rdy);
        bit kept;
        bit pop;
        bit full;
        x_valid = v;
        x       = DW'(xv);
        y_ready = rdy;
        kept = 1'b0;
        if (v) begin
            if (acc >= WU) kept = (((acc - WU) % 2) == 0);
            acc++;
        end
        full = (q.size() == D);
        pop  = (q.size() > 0) && rdy;
        if (yv0 && rdy) seq0.push_back(int'(y0));
        if (yv1 && rdy) seq1.push_back(int'(y1));
        if (pop) void'(q.pop_front());
        if (kept) begin
            if (!full || pop) q.push_back(xv);
            else begin
                drops++;
                ovf_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("y", 32'(y0), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk("y_valid", 32'(yv0), (q.size() > 0) ? 32'd1 : 32'd0);
        chk("level", 32'(lvl0), 32'(q.size()));
`ifdef DECIM_OVF_EN
        chk("ovf", 32'(ovf0), 32'(ovf_m));
        chk("drop_cnt", 32'(dc0), (drops > 255) ? 32'd255 : 32'(drops));
`endif
    endtask

    // Assert reset mid-cycle, check outputs before any edge, release just after an edge.
    task automatic do_reset();
        rst     = 1'b1;
        x_valid = 1'b0;
        y_ready = 1'b0;
        x       = '0;
        #2;
        chk("rst_y0", 32'(y0), 32'd0);
        chk("rst_valid0", 32'(yv0), 32'd0);
        chk("rst_level0", 32'(lvl0), 32'd0);
        chk("rst_valid1", 32'(yv1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        seq0.delete();
        seq1.delete();
    endtask

    initial begin
        int lv;
        rst     = 1'b1;
        x_valid = 1'b0;
        y_ready = 1'b0;
        x       = '0;
        #1;

        // Build the table for the back-pressure scenario: 1..29 with y_ready=0, then drain.
        for (int i = 1; i <= 29; i++) begin
            if (i < 10) tbl.push_back('{1'b1, i, 1'b0, 0, 1'b0, 0});
            else begin
                lv = (i - 10) / 2 + 1;
                if (lv > D) lv = D;
                tbl.push_back('{1'b1, i, 1'b0, 10, 1'b1, lv});
            end
        end
        tbl.push_back('{1'b0, 0, 1'b1, 12, 1'b1, 3});
        tbl.push_back('{1'b0, 0, 1'b1, 14, 1'b1, 2});
        tbl.push_back('{1'b0, 0, 1'b1, 16, 1'b1, 1});
        tbl.push_back('{1'b0, 0, 1'b1, 0,  1'b0, 0});

        // Free-running 1..40, both phases.
        do_reset();
        for (int i = 1; i <= 40; i++) step(1'b1, i, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1);
        chk("seq0_len", 32'(seq0.size()), 32'd16);
        for (int i = 0; i < seq0.size() && i < 16; i++) chk("seq0", 32'(seq0[i]), 32'(10 + 2 * i));
        chk("seq1_len", 32'(seq1.size()), 32'd15);
        for (int i = 0; i < seq1.size() && i < 15; i++) chk("seq1", 32'(seq1[i]), 32'(11 + 2 * i));

        // Back-pressure table.
        do_reset();
        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].xv, tbl[k].rdy);
            chk("tbl_y", 32'(y0), 32'(tbl[k].ey));
            chk("tbl_valid", 32'(yv0), 32'(tbl[k].ev));
            chk("tbl_level", 32'(lvl0), 32'(tbl[k].el));
`ifdef DECIM_OVF_EN
            if (k == 28) begin
                chk("tbl_ovf", 32'(ovf0), 32'd1);
                chk("tbl_drop_cnt", 32'(dc0), 32'd6);
            end
`endif
        end

        // Full FIFO with a keep cycle and simultaneous pop.
        do_reset();
        for (int i = 1; i <= 17; i++) step(1'b1, i, 1'b0);
        chk("full_level", 32'(lvl0), 32'd4);
        step(1'b1, 18, 1'b1);
        chk("fullpp_level", 32'(lvl0), 32'd4);
        chk("fullpp_y", 32'(y0), 32'd12);
`ifdef DECIM_OVF_EN
        chk("fullpp_ovf", 32'(ovf0), 32'd0);
`endif
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1);
        chk("full_order_len", 32'(seq0.size()), 32'd5);
        for (int i = 0; i < seq0.size() && i < 5; i++) chk("full_order", 32'(seq0[i]), 32'(10 + 2 * i));

        // x_valid toggling with junk on idle cycles.
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, i, 1'b1);
            step(1'b0, int'($urandom_range(0, 2047)), 1'b1);
        end
        chk("tog_len", 32'(seq0.size()), 32'd16);
        for (int i = 0; i < seq0.size() && i < 16; i++) chk("tog_seq", 32'(seq0[i]), 32'(10 + 2 * i));

        // Mid-cycle reset with level=3, then warm-up must restart.
        do_reset();
        for (int i = 1; i <= 15; i++) step(1'b1, i, 1'b0);
        chk("pre_rst_level", 32'(lvl0), 32'd3);
        #3;
        do_reset();
        for (int i = 101; i <= 109; i++) step(1'b1, i, 1'b1);
        chk("rewarm_valid", 32'(yv0), 32'd0);
        step(1'b1, 110, 1'b1);
        chk("rewarm_first", 32'(y0), 32'd110);

        // Randomized stimulus against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 2047)),
                 (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
